sdiv18: RTL and testbench

SDIV18 -- requirements
Module: sdiv18

---
 rtl/sdiv18.sv | 157 +++++++++++++++
 tb/tb_sdiv18.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdiv18.sv
// Sequential 18-bit signed divider: a radix-2 restoring core on magnitudes, then a sign fix-up stage.
// Optional macro SDIV18_EARLY_DIVZ_EN lets a zero-divisor request finish one edge after START.
module sdiv18 (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic signed [17:0] A,
  input  logic signed [17:0] B,
  output logic               BUSY,
  output logic               DONE,
  output logic signed [17:0] Q,
  output logic signed [17:0] R,
  output logic               DIVZ,
  output logic               OVF
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic signed [17:0] q_q, q_d;
  logic signed [17:0] r_q, r_d;
  logic               divz_q, divz_d;
  logic               ovf_q, ovf_d;

  logic [18:0]        rem_q, rem_d;
  logic [17:0]        quo_q, quo_d;
  logic [18:0]        div_q, div_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d, ov_q, ov_d;

  logic [18:0]        rem_sh;
  logic [18:0]        rem_sub;

  function automatic logic [17:0] mag18(input logic signed [17:0] x);
    logic [17:0] v;
    v = x;
    return x[17] ? (~v + 18'd1) : v;
  endfunction

  function automatic logic signed [17:0] apply_sign(input logic [17:0] mag, input logic neg);
    return neg ? $signed(~mag + 18'd1) : $signed(mag);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    divz_d  = divz_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    rem_sh  = {rem_q[17:0], quo_q[17]};
    rem_sub = rem_sh - div_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          sa_d    = A[17];
          sb_d    = B[17];
          quo_d   = mag18(A);
          div_d   = {1'b0, mag18(B)};
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          dz_d    = (B == 18'sd0);
          ov_d    = (A == -18'sd131072) && (B == -18'sd1);
          state_d = CALC;
`ifdef SDIV18_EARLY_DIVZ_EN
          // Zero divisor: preload the remainder the iterations would have produced and skip them.
          if (B == 18'sd0) begin
            rem_d   = {1'b0, mag18(A)};
            state_d = SIGN;
          end
`endif
        end
      end
      CALC: begin
        if (rem_sh >= div_q) begin
          rem_d = rem_sub;
          quo_d = {quo_q[16:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[16:0], 1'b0};
        end
        if (cnt_q == 5'd17) begin
          cnt_d   = '0;
          state_d = SIGN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      SIGN: begin
        // A zero divisor saturates the quotient toward the dividend's sign; remainder is A itself.
        if (dz_q) q_d = sa_q ? -18'sd131072 : 18'sd131071;
        else      q_d = apply_sign(quo_q, sa_q ^ sb_q);
        r_d     = apply_sign(rem_q[17:0], sa_q);
        divz_d  = dz_q;
        ovf_d   = ov_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      divz_q  <= divz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    div_q <= div_d;
    sa_q  <= sa_d;
    sb_q  <= sb_d;
    dz_q  <= dz_d;
    ov_q  <= ov_d;
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign DIVZ = divz_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_sdiv18.sv
// Bench for sdiv18: directed corner cases plus random operands against an integer-arithmetic model.
module tb_sdiv18;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic               START;
  logic signed [17:0] A, B;
  logic               BUSY, DONE, DIVZ, OVF;
  logic signed [17:0] Q, R;

  int errors = 0;
  int checks = 0;

  sdiv18 dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .DIVZ(DIVZ), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Reference: truncating integer division with the documented special cases.
  function automatic void model(input int a, input int b,
                                output logic signed [17:0] q, output logic signed [17:0] r,
                                output logic dz, output logic ov);
    int qi, ri;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      qi = (a >= 0) ? 131071 : -131072;
      ri = a;
    end else if (a == -131072 && b == -1) begin
      ov = 1'b1;
      qi = -131072;
      ri = 0;
    end else begin
      qi = a / b;
      ri = a % b;
    end
    q = 18'(qi);
    r = 18'(ri);
  endfunction

  function automatic int exp_lat(input int b);
`ifdef SDIV18_EARLY_DIVZ_EN
    return (b == 0) ? 1 : 19;
`else
    return 19;
`endif
  endfunction

  // Called at posedge+1. Launches one operation; returns edges from the accepting edge to DONE (-1 on timeout).
  task automatic do_op(input logic signed [17:0] a, input logic signed [17:0] b, output int lat);
    START = 1'b1;
    A = a;
    B = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = 18'($urandom);
    B = 18'($urandom);
    lat = -1;
    if (DONE) lat = 0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge CLK);
      #1;
      if (DONE) lat = n;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    START = 1'b1;
    A = 18'sd100;
    B = 18'sd7;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({BUSY, DONE, DIVZ, OVF} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/divz/ovf=%b required 0000", {BUSY, DONE, DIVZ, OVF});
    end
    checks++;
    if (Q !== 18'sd0 || R !== 18'sd0) begin
      errors++;
      $display("FAIL reset_data: Q=%h R=%h required 0 0", Q, R);
    end
    START = 1'b0;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_directed();
    int ta[10] = '{100, -100, 100, -131072, 5, -5, -131072, 131071, -131072, 0};
    int tb[10] = '{7, 7, -7, -1, 0, 0, 0, 1, 1, -3};
    logic signed [17:0] eq, er;
    logic edz, eov;
    int lat;
    for (int i = 0; i < 10; i++) begin
      model(ta[i], tb[i], eq, er, edz, eov);
      do_op(18'(ta[i]), 18'(tb[i]), lat);
      checks++;
      if (lat != exp_lat(tb[i])) begin
        errors++;
        $display("FAIL dir_latency %0d/%0d: got %0d required %0d", ta[i], tb[i], lat, exp_lat(tb[i]));
      end
      checks++;
      if (Q !== eq || R !== er) begin
        errors++;
        $display("FAIL dir_qr %0d/%0d: Q=%h R=%h required Q=%h R=%h", ta[i], tb[i], Q, R, eq, er);
      end
      checks++;
      if (DIVZ !== edz || OVF !== eov || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL dir_flags %0d/%0d: divz=%b ovf=%b busy=%b required %b %b 0",
                 ta[i], tb[i], DIVZ, OVF, BUSY, edz, eov);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_random();
    logic signed [17:0] eq, er, ra, rb;
    logic edz, eov;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = 18'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 18'(int'($urandom_range(0, 20)) - 10);
        1: rb = 18'(int'($urandom_range(0, 2000)) - 1000);
        default: rb = 18'($urandom);
      endcase
      model(int'(ra), int'(rb), eq, er, edz, eov);
      do_op(ra, rb, lat);
      checks++;
      if (lat != exp_lat(int'(rb)) || Q !== eq || R !== er || DIVZ !== edz || OVF !== eov) begin
        errors++;
        $display("FAIL rand %0d/%0d: lat=%0d Q=%h R=%h dz=%b ov=%b required lat=%0d Q=%h R=%h dz=%b ov=%b",
                 ra, rb, lat, Q, R, DIVZ, OVF, exp_lat(int'(rb)), eq, er, edz, eov);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic test_hold();
    logic signed [17:0] eq, er;
    logic edz, eov;
    int lat;
    model(-131072, -1, eq, er, edz, eov);
    do_op(-18'sd131072, -18'sd1, lat);
    A = 18'sd3;
    B = 18'sd0;
    for (int n = 0; n < 8; n++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (DONE !== 1'b0 || Q !== eq || R !== er || OVF !== eov || DIVZ !== edz) begin
        errors++;
        $display("FAIL hold cyc%0d: done=%b Q=%h R=%h ovf=%b divz=%b required 0 %h %h %b %b",
                 n, DONE, Q, R, OVF, DIVZ, eq, er, eov, edz);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [17:0] eq, er;
    logic edz, eov;
    int lat, seen;
    START = 1'b1;
    A = 18'sd1000;
    B = -18'sd9;
    @(posedge CLK);                 // edge 0
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);      // edges 1..4
    #1;
    START = 1'b1;
    A = 18'sd77;
    B = 18'sd0;
    @(posedge CLK);                 // edge 5, must be ignored
    #1;
    START = 1'b0;
    lat = -1;
    for (int n = 6; n <= 40 && lat < 0; n++) begin
      @(posedge CLK);
      #1;
      if (DONE) lat = n;
    end
    model(1000, -9, eq, er, edz, eov);
    checks++;
    if (lat != 19 || Q !== eq || R !== er || DIVZ !== edz) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d Q=%h R=%h divz=%b required lat=19 Q=%h R=%h divz=%b",
               lat, Q, R, DIVZ, eq, er, edz);
    end
    // START during the DONE cycle: next DONE must arrive 20 edges after this one.
    model(-32768, 5, eq, er, edz, eov);
    do_op(-18'sd32768, 18'sd5, lat);
    checks++;
    if (lat + 1 != 20 || Q !== eq || R !== er) begin
      errors++;
      $display("FAIL back_to_back: period=%0d Q=%h R=%h required period=20 Q=%h R=%h",
               lat + 1, Q, R, eq, er);
    end
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge CLK);
      #1;
      if (DONE) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL no_stray_done: got %0d pulses required 0", seen);
    end
  endtask

  task automatic test_mid_reset();
    logic signed [17:0] eq, er;
    logic edz, eov;
    int lat, seen;
    do_op(18'sd100, 18'sd7, lat);   // leaves nonzero outputs behind
    START = 1'b1;
    A = -18'sd500;
    B = 18'sd3;
    @(posedge CLK);                 // edge 0
    #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);      // edges 1..9
    #1;
    RST_N = 1'b0;
    START = 1'b1;
    @(posedge CLK);                 // edge 10
    #1;
    checks++;
    if ({BUSY, DONE, DIVZ, OVF} !== 4'b0000 || Q !== 18'sd0 || R !== 18'sd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b divz=%b ovf=%b Q=%h R=%h required all 0",
               BUSY, DONE, DIVZ, OVF, Q, R);
    end
    repeat (3) @(posedge CLK);
    #1;
    START = 1'b0;
    RST_N = 1'b1;
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge CLK);
      #1;
      if (DONE || BUSY) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_reset_abort: %0d cycles with done/busy required 0", seen);
    end
    model(-100, 7, eq, er, edz, eov);
    do_op(-18'sd100, 18'sd7, lat);
    checks++;
    if (lat != 19 || Q !== eq || R !== er) begin
      errors++;
      $display("FAIL post_reset_op: lat=%0d Q=%h R=%h required lat=19 Q=%h R=%h", lat, Q, R, eq, er);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    A = '0;
    B = '0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
